// File: rtl/hilo_mult_ctrl.sv
// Execute-stage sequencer for the shared HI/LO multiplier: registers operands,
// counts the fixed multiplier latency and owns the architectural HI/LO pair.
module hilo_mult_ctrl #(
    parameter int MUL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_signed,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    localparam int CW = $clog2(MUL_LATENCY) + 1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd3;
    localparam logic [2:0] OP_MTLO  = 3'd4;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          accept;
    logic          is_mul;
    logic          finish;

    assign req_ready = (state == IDLE) & resetn;
    assign accept    = req_valid & req_ready & ~flush;
    assign is_mul    = (req_op == OP_MULT) || (req_op == OP_MULTU);
    assign busy      = (state == RUN);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (accept && is_mul) begin
                    state_nxt = RUN;
                    cnt_nxt   = CW'(MUL_LATENCY - 1);
                end
            end
            RUN: begin
                // Flush wins even in the completion cycle: no writeback.
                if (flush) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mul_a      <= '0;
            mul_b      <= '0;
            mul_signed <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            done       <= 1'b0;
        end else begin
            done <= finish;
            if (accept && is_mul) begin
                mul_a      <= req_a;
                mul_b      <= req_b;
                mul_signed <= (req_op == OP_MULT);
            end
            // Completion only happens in RUN and moves are only accepted in
            // IDLE, so these two writers never collide.
            if (finish) begin
                hi <= mul_hi;
                lo <= mul_lo;
            end else if (accept && req_op == OP_MTHI) begin
                hi <= req_a;
            end else if (accept && req_op == OP_MTLO) begin
                lo <= req_a;
            end
        end
    end

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Scoreboarded bench for hilo_mult_ctrl: a 3-cycle instance and a
// 1-cycle (combinational multiplier) instance driven by directed vectors.
module tb_hilo_mult_ctrl;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd3;
    localparam logic [2:0] OP_MTLO  = 3'd4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] q3[$];
    logic [63:0] q1[$];

    // Instance with MUL_LATENCY=3
    logic        resetn3, valid3, ready3, flush3, msigned3, busy3, done3;
    logic [2:0]  op3;
    logic [31:0] a3, b3, ma3, mb3, mhi3, mlo3, hi3, lo3;

    // Instance with MUL_LATENCY=1
    logic        resetn1, valid1, ready1, flush1, msigned1, busy1, done1;
    logic [2:0]  op1;
    logic [31:0] a1, b1, ma1, mb1, mhi1, mlo1, hi1, lo1;

    hilo_mult_ctrl #(.MUL_LATENCY(3)) dut3 (
        .clk(clk), .resetn(resetn3), .req_valid(valid3), .req_ready(ready3),
        .req_op(op3), .req_a(a3), .req_b(b3), .flush(flush3),
        .mul_a(ma3), .mul_b(mb3), .mul_signed(msigned3),
        .mul_hi(mhi3), .mul_lo(mlo3), .hi(hi3), .lo(lo3),
        .busy(busy3), .done(done3)
    );

    hilo_mult_ctrl #(.MUL_LATENCY(1)) dut1 (
        .clk(clk), .resetn(resetn1), .req_valid(valid1), .req_ready(ready1),
        .req_op(op1), .req_a(a1), .req_b(b1), .flush(flush1),
        .mul_a(ma1), .mul_b(mb1), .mul_signed(msigned1),
        .mul_hi(mhi1), .mul_lo(mlo1), .hi(hi1), .lo(lo1),
        .busy(busy1), .done(done1)
    );

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b,
                                         input logic s);
        if (s) return {{32{a[31]}}, a} * {{32{b[31]}}, b};
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Multiplier models: 3-cycle one shows the product only on the third
    // cycle the operands are presented; earlier cycles show a stale value.
    logic [63:0] p1 = '0, p2 = '0;
    always @(posedge clk) begin
        p1 <= prod(ma3, mb3, msigned3);
        p2 <= p1;
    end
    assign {mhi3, mlo3} = p2;
    assign {mhi1, mlo1} = prod(ma1, mb1, msigned1);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue3(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        check("ready3_before_issue", 64'(ready3), 64'd1);
        valid3 = 1'b1; op3 = op; a3 = a; b3 = b;
        step();
        valid3 = 1'b0; op3 = OP_NOP;
    endtask

    task automatic issue1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        check("ready1_before_issue", 64'(ready1), 64'd1);
        valid1 = 1'b1; op1 = op; a1 = a; b1 = b;
        step();
        valid1 = 1'b0; op1 = OP_NOP;
    endtask

    // Monitors: pop the expected {hi,lo} whenever a done pulse is presented.
    initial forever begin
        @(negedge clk);
        if (resetn3 && done3) begin
            if (q3.size() == 0) check("unexpected_done3", {hi3, lo3}, 64'hx);
            else check("result3", {hi3, lo3}, q3.pop_front());
        end
    end

    initial forever begin
        @(negedge clk);
        if (resetn1 && done1) begin
            if (q1.size() == 0) check("unexpected_done1", {hi1, lo1}, 64'hx);
            else check("result1", {hi1, lo1}, q1.pop_front());
        end
    end

    initial begin
        resetn3 = 1'b0; valid3 = 1'b0; op3 = OP_NOP; a3 = '0; b3 = '0; flush3 = 1'b0;
        resetn1 = 1'b0; valid1 = 1'b0; op1 = OP_NOP; a1 = '0; b1 = '0; flush1 = 1'b0;
        step();
        step();
        check("reset_hilo", {hi3, lo3}, 64'h0);
        check("reset_ops", {ma3, mb3}, 64'h0);
        check("reset_flags", {61'b0, busy3, done3, ready3}, 64'h0);
        resetn3 = 1'b1; resetn1 = 1'b1;
        step();

        // 1: MULT -1 x 2
        q3.push_back(64'hFFFFFFFF_FFFFFFFE);
        issue3(OP_MULT, 32'hFFFFFFFF, 32'h00000002);
        check("t1_ops", {ma3, mb3}, 64'hFFFFFFFF_00000002);
        check("t1_signed", 64'(msigned3), 64'd1);
        for (int i = 0; i < 3; i++) begin
            check("t1_busy", {62'b0, busy3, ready3}, 64'b10);
            step();
        end
        check("t1_done", {62'b0, done3, ready3}, 64'b11);
        check("t1_busy_low", 64'(busy3), 64'd0);
        step();
        check("t1_done_once", 64'(done3), 64'd0);

        // 2: MULTU same operands
        q3.push_back(64'h00000001_FFFFFFFE);
        issue3(OP_MULTU, 32'hFFFFFFFF, 32'h00000002);
        check("t2_signed", 64'(msigned3), 64'd0);
        step(); step(); step();
        check("t2_done", 64'(done3), 64'd1);
        step();

        // 3: moves, then MTHI offered while a multiply runs
        issue3(OP_MTHI, 32'h12345678, 32'h0);
        check("t3_mthi", 64'(hi3), 64'h12345678);
        issue3(OP_MTLO, 32'h9ABCDEF0, 32'h0);
        check("t3_mtlo", {hi3, lo3}, 64'h12345678_9ABCDEF0);
        check("t3_no_done", 64'(done3), 64'd0);
        q3.push_back(64'h00000000_0000000F);
        issue3(OP_MULT, 32'd3, 32'd5);
        valid3 = 1'b1; op3 = OP_MTHI; a3 = 32'hAAAA5555;
        check("t3_blocked_ready", 64'(ready3), 64'd0);
        step();
        check("t3_held_hi_a", 64'(hi3), 64'h12345678);
        step();
        check("t3_held_hi_b", 64'(hi3), 64'h12345678);
        step();
        check("t3_ready_in_done", {62'b0, done3, ready3}, 64'b11);
        step();
        valid3 = 1'b0; op3 = OP_NOP;
        check("t3_late_mthi", {hi3, lo3}, 64'hAAAA5555_0000000F);

        // 4: flush in T+2, then flush in the completion cycle T+3
        issue3(OP_MTHI, 32'h11111111, 32'h0);
        issue3(OP_MTLO, 32'h22222222, 32'h0);
        issue3(OP_MULT, 32'h10, 32'h10);
        step();
        flush3 = 1'b1;
        step();
        flush3 = 1'b0;
        check("t4a_idle", {62'b0, busy3, ready3}, 64'b01);
        step(); step();
        check("t4a_hilo", {hi3, lo3}, 64'h11111111_22222222);
        issue3(OP_MULT, 32'h20, 32'h20);
        step(); step();
        flush3 = 1'b1;
        step();
        flush3 = 1'b0;
        check("t4b_idle", {61'b0, busy3, done3, ready3}, 64'b001);
        step(); step();
        check("t4b_hilo", {hi3, lo3}, 64'h11111111_22222222);
        // flush in IDLE drops the offered move
        valid3 = 1'b1; op3 = OP_MTHI; a3 = 32'hDEADBEEF; flush3 = 1'b1;
        step();
        valid3 = 1'b0; op3 = OP_NOP; flush3 = 1'b0;
        step();
        check("t4c_idle_flush", {hi3, lo3}, 64'h11111111_22222222);

        // 5: reset mid-RUN, then 7 x -3
        issue3(OP_MULT, 32'd5, 32'd5);
        step();
        resetn3 = 1'b0;
        #2;
        check("t5_async_hilo", {hi3, lo3}, 64'h0);
        check("t5_async_flags", {61'b0, busy3, done3, ready3}, 64'h0);
        resetn3 = 1'b1;
        step();
        q3.push_back(64'hFFFFFFFF_FFFFFFEB);
        issue3(OP_MULT, 32'd7, 32'hFFFFFFFD);
        step(); step(); step();
        check("t5_done", 64'(done3), 64'd1);
        step();

        // 6: latency 1, back-to-back in the done cycle
        q1.push_back(64'h00000000_0000000C);
        q1.push_back(64'h00000000_0000001E);
        issue1(OP_MULT, 32'd3, 32'd4);
        check("t6_busy", 64'(busy1), 64'd1);
        step();
        check("t6_done_a", {62'b0, done1, ready1}, 64'b11);
        issue1(OP_MULT, 32'd5, 32'd6);
        check("t6_gap", {62'b0, done1, busy1}, 64'b01);
        step();
        check("t6_done_b", 64'(done1), 64'd1);
        step(); step();

        check("q3_drained", 64'(q3.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
